// File: rtl/mul_result_collector.sv
// Result collector for the FP multiplier: buffers core results in a show-ahead FIFO,
// tracks in-flight operations and exports an issue credit to the driver.
module mul_result_collector #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic [31:0]   res_in,
    input  logic          res_rdy,
    output logic [31:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          can_issue,
    output logic [CW-1:0] inflight,
    output logic [CW-1:0] level,
    output logic          err_credit,
    output logic          err_orphan,
    output logic          err_ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] INF_MAX = {CW{1'b1}};

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q, level_d, inflight_q, inflight_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          err_credit_q, err_credit_d;
    logic          err_orphan_q, err_orphan_d;
    logic          err_ovf_q, err_ovf_d;
    logic          pop, push, dec;

    assign out_valid  = (level_q != '0);
    assign out_data   = out_data_q;
    assign level      = level_q;
    assign inflight   = inflight_q;
    assign err_credit = err_credit_q;
    assign err_orphan = err_orphan_q;
    assign err_ovf    = err_ovf_q;
    assign can_issue  = ({1'b0, inflight_q} + {1'b0, level_q}) < {1'b0, DEPTH_C};

    always_comb begin
        pop          = out_valid & out_ready;
        push         = res_rdy & ((level_q != DEPTH_C) | pop);
        dec          = res_rdy & (inflight_q != '0);
        rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        level_d      = level_q + CW'(push) - CW'(pop);
        inflight_d   = inflight_q;
        err_credit_d = err_credit_q | (issue & ~can_issue);
        err_orphan_d = err_orphan_q | (res_rdy & (inflight_q == '0));
        err_ovf_d    = err_ovf_q | (res_rdy & ~push);
        out_data_d   = out_data_q;

        if (issue && !dec)
            inflight_d = (inflight_q == INF_MAX) ? INF_MAX : inflight_q + CW'(1);
        else if (!issue && dec)
            inflight_d = inflight_q - CW'(1);

        // Keep the head register in step with the array; the new head may be the word written this edge.
        if (level_d != '0)
            out_data_d = (push && (wr_ptr_q == rd_ptr_d)) ? res_in : mem_q[rd_ptr_d];

        if (rst) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            level_d      = '0;
            inflight_d   = '0;
            out_data_d   = '0;
            err_credit_d = 1'b0;
            err_orphan_d = 1'b0;
            err_ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem_q[wr_ptr_q] <= res_in;
    end

    always_ff @(posedge clk) begin
        rd_ptr_q     <= rd_ptr_d;
        wr_ptr_q     <= wr_ptr_d;
        level_q      <= level_d;
        inflight_q   <= inflight_d;
        out_data_q   <= out_data_d;
        err_credit_q <= err_credit_d;
        err_orphan_q <= err_orphan_d;
        err_ovf_q    <= err_ovf_d;
    end

endmodule
